reset_sequencer: RTL and testbench

Consumes the POR output of the caravel-side power-on reset (`porb_l`, wired to `rst_n_in`) and turns it into staged, per-domain, synchronously released resets for the SoC's digital domains. It also adds a soft-reset request/acknowledge path and a watchdog-bite path. Both re-assert all domain resets and then replay the staged release. It sits between the POR block and every downstream reset consumer, such as the core, peripherals and housekeeping.

---
 rtl/reset_seq_pkg.sv | 29 ++
 rtl/reset_sync.sv | 31 +++
 rtl/reset_sequencer.sv | 144 ++++++++++++++
 tb/tb_reset_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_pkg
// Description : Shared types and constants for the staged reset sequencer.
//               Defines the sequencer state encoding, the reset-cause codes
//               reported on reset_cause, and a small helper used to size the
//               shared stage/hold counter.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    // Sequencer states, explicitly encoded in two bits.
    typedef enum logic [1:0] {
        RELEASE = 2'd0,
        RUN     = 2'd1,
        HOLD    = 2'd2
    } seq_state_e;

    // Last-reset-cause codes (2'b00 is never reported).
    localparam logic [1:0] CAUSE_POR  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;
    localparam logic [1:0] CAUSE_WDT  = 2'b11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sync.sv
`default_nettype none
// ============================================================================
// Module      : reset_sync
// Description : Two-flop reset synchronizer. Assertion is asynchronous,
//               deassertion is aligned to clk and appears two rising edges
//               after the asynchronous input goes high.
// Ports       : clk      - clock of the destination domain
//               i_arst_n - asynchronous active-low reset in
//               o_rst_n  - active-low reset, synchronously released
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sync (
    input  logic clk,
    input  logic i_arst_n,
    output logic o_rst_n
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign o_rst_n = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Turns the power-on reset into staged, per-domain resets that
//               are released one domain at a time (index 0 first). A soft
//               reset request (acknowledged for one cycle) or a watchdog bite
//               re-asserts every domain, holds them for HOLD_CYCLES and then
//               replays the staged release.
// Ports       : clk          - single clock
//               rst_n_in     - asynchronous active-low reset (POR porb_l)
//               soft_rst_req - level soft-reset request, held until acked
//               wdt_bite     - watchdog reset request
//               dom_rst_n    - per-domain active-low resets
//               seq_done     - all domains released
//               soft_rst_ack - one-cycle acknowledge of a soft request
//               reset_cause  - last reset cause (only with RESET_CAUSE_EN)
// Config      : define RESET_CAUSE_EN to add the reset_cause port/register.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS  = 4,
    parameter int STAGE_CYCLES = 16,
    parameter int HOLD_CYCLES  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n_in,
    input  logic                   soft_rst_req,
    input  logic                   wdt_bite,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic                   seq_done,
    output logic                   soft_rst_ack
`ifdef RESET_CAUSE_EN
    ,
    output logic [1:0]             reset_cause
`endif
);

    localparam int CNT_W = $clog2(max_int(STAGE_CYCLES, HOLD_CYCLES) + 1);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    // The counter value on the edge that completes a stage / hold period.
    localparam logic [CNT_W-1:0] C_STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST   = IDX_W'(NUM_DOMAINS - 1);

    logic                   rst_sync_n;
    seq_state_e             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_DOMAINS-1:0] r_dom_rst_n;
    logic                   r_seq_done;
    logic                   r_soft_rst_ack;
    logic                   w_enter_hold;
    logic                   w_soft_accept;
    logic [NUM_DOMAINS-1:0] w_release_mask;

    reset_sync u_reset_sync (
        .clk      (clk),
        .i_arst_n (rst_n_in),
        .o_rst_n  (rst_sync_n)
    );

    // A soft request is only honoured in RUN; a bite is honoured everywhere
    // and, in HOLD, restarts the hold period.
    assign w_soft_accept  = (r_state == RUN) && soft_rst_req;
    assign w_enter_hold   = wdt_bite || w_soft_accept;
    assign w_release_mask = NUM_DOMAINS'(1) << r_idx;

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            r_state        <= RELEASE;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_dom_rst_n    <= '0;
            r_seq_done     <= 1'b0;
            r_soft_rst_ack <= 1'b0;
        end else begin
            r_soft_rst_ack <= 1'b0;
            if (w_enter_hold) begin
                r_state        <= HOLD;
                r_cnt          <= '0;
                r_idx          <= '0;
                r_dom_rst_n    <= '0;
                r_seq_done     <= 1'b0;
                r_soft_rst_ack <= w_soft_accept;
            end else begin
                unique case (r_state)
                    RELEASE: begin
                        if (r_cnt == C_STAGE_LAST) begin
                            r_cnt       <= '0;
                            r_dom_rst_n <= r_dom_rst_n | w_release_mask;
                            if (r_idx == C_IDX_LAST) begin
                                r_seq_done <= 1'b1;
                                r_state    <= RUN;
                            end else begin
                                r_idx <= r_idx + IDX_W'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    RUN: begin
                        r_cnt <= '0;
                    end
                    HOLD: begin
                        if (r_cnt == C_HOLD_LAST) begin
                            r_cnt   <= '0;
                            r_state <= RELEASE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= RELEASE;
                    end
                endcase
            end
        end
    end

    assign dom_rst_n    = r_dom_rst_n;
    assign seq_done     = r_seq_done;
    assign soft_rst_ack = r_soft_rst_ack;

`ifdef RESET_CAUSE_EN
    logic [1:0] r_reset_cause;

    // Watchdog wins over a simultaneous soft request.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            r_reset_cause <= CAUSE_POR;
        end else if (w_enter_hold) begin
            r_reset_cause <= wdt_bite ? CAUSE_WDT : CAUSE_SOFT;
        end
    end

    assign reset_cause = r_reset_cause;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Directed self-checking bench for reset_sequencer with
//               NUM_DOMAINS=4, STAGE_CYCLES=4, HOLD_CYCLES=8. Edge numbers
//               count rising clk edges since rst_n_in was last released.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    logic       clk;
    logic       rst_n_in;
    logic       soft_rst_req;
    logic       wdt_bite;
    logic [3:0] dom_rst_n;
    logic       seq_done;
    logic       soft_rst_ack;
`ifdef RESET_CAUSE_EN
    logic [1:0] reset_cause;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int ed       = 0;

    reset_sequencer #(
        .NUM_DOMAINS  (4),
        .STAGE_CYCLES (4),
        .HOLD_CYCLES  (8)
    ) dut (
        .clk          (clk),
        .rst_n_in     (rst_n_in),
        .soft_rst_req (soft_rst_req),
        .wdt_bite     (wdt_bite),
        .dom_rst_n    (dom_rst_n),
        .seq_done     (seq_done),
        .soft_rst_ack (soft_rst_ack)
`ifdef RESET_CAUSE_EN
        ,
        .reset_cause  (reset_cause)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, ed, obs, exp);
        end
    endtask

    task automatic check_cause(input logic [1:0] exp);
`ifdef RESET_CAUSE_EN
        check("cause", {30'd0, reset_cause}, {30'd0, exp});
`else
        check("cause_absent_done_ok", {31'd0, seq_done}, {31'd0, seq_done === 1'b1});
`endif
    endtask

    // Advance to 1 time unit after the given edge.
    task automatic goto(input int n);
        while (ed < n) begin
            @(posedge clk);
            ed++;
            #1;
        end
    endtask

    task automatic release_por();
        @(negedge clk);
        rst_n_in = 1'b1;
        ed       = 0;
    endtask

    initial begin
        rst_n_in     = 1'b0;
        soft_rst_req = 1'b0;
        wdt_bite     = 1'b0;
        #12;
        check("rst_dom",  {28'd0, dom_rst_n},  32'h0);
        check("rst_done", {31'd0, seq_done},   32'h0);
        check("rst_ack",  {31'd0, soft_rst_ack}, 32'h0);

        // Power-up, with a soft request held across RELEASE (edges 3..10).
        release_por();
        goto(2);
        soft_rst_req = 1'b1;
        for (int e = 3; e <= 10; e++) begin
            goto(e);
            check("ign_ack", {31'd0, soft_rst_ack}, 32'h0);
        end
        soft_rst_req = 1'b0;
        goto(5);
        goto(11);
        check("pu_dom11", {28'd0, dom_rst_n}, 32'h3);
        goto(13);
        check("pu_dom13", {28'd0, dom_rst_n}, 32'h3);
        goto(14);
        check("pu_dom14", {28'd0, dom_rst_n}, 32'h7);
        goto(17);
        check("pu_done17", {31'd0, seq_done}, 32'h0);
        goto(18);
        check("pu_dom18",  {28'd0, dom_rst_n}, 32'hF);
        check("pu_done18", {31'd0, seq_done},  32'h1);
        check_cause(2'b01);

        // Soft reset sampled at edge 30.
        goto(29);
        soft_rst_req = 1'b1;
        goto(30);
        soft_rst_req = 1'b0;
        check("sr_dom30",  {28'd0, dom_rst_n},    32'h0);
        check("sr_done30", {31'd0, seq_done},     32'h0);
        check("sr_ack30",  {31'd0, soft_rst_ack}, 32'h1);
`ifdef RESET_CAUSE_EN
        check("sr_cause", {30'd0, reset_cause}, 32'h2);
`endif
        goto(31);
        check("sr_ack31", {31'd0, soft_rst_ack}, 32'h0);
        goto(41);
        check("sr_dom41", {28'd0, dom_rst_n}, 32'h0);
        goto(42);
        check("sr_dom42", {28'd0, dom_rst_n}, 32'h1);
        goto(46);
        check("sr_dom46", {28'd0, dom_rst_n}, 32'h3);
        goto(50);
        check("sr_dom50", {28'd0, dom_rst_n}, 32'h7);
        goto(53);
        check("sr_done53", {31'd0, seq_done}, 32'h0);
        goto(54);
        check("sr_dom54",  {28'd0, dom_rst_n}, 32'hF);
        check("sr_done54", {31'd0, seq_done},  32'h1);

        // Asynchronous reset between edges.
        goto(60);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("ar_dom",  {28'd0, dom_rst_n},    32'h0);
        check("ar_done", {31'd0, seq_done},     32'h0);
        check("ar_ack",  {31'd0, soft_rst_ack}, 32'h0);
`ifdef RESET_CAUSE_EN
        check("ar_cause", {30'd0, reset_cause}, 32'h1);
`endif
        @(negedge clk);

        // Re-release: power-up timing repeats, then a bite at edge 12.
        release_por();
        goto(5);
        check("rr_dom5", {28'd0, dom_rst_n}, 32'h0);
        goto(6);
        check("rr_dom6", {28'd0, dom_rst_n}, 32'h1);
        goto(10);
        check("rr_dom10", {28'd0, dom_rst_n}, 32'h3);
        goto(11);
        wdt_bite = 1'b1;
        goto(12);
        wdt_bite = 1'b0;
        check("wd_dom12", {28'd0, dom_rst_n},    32'h0);
        check("wd_ack12", {31'd0, soft_rst_ack}, 32'h0);
`ifdef RESET_CAUSE_EN
        check("wd_cause", {30'd0, reset_cause}, 32'h3);
`endif
        goto(23);
        check("wd_dom23", {28'd0, dom_rst_n}, 32'h0);
        goto(24);
        check("wd_dom24", {28'd0, dom_rst_n}, 32'h1);
        goto(36);
        check("wd_dom36",  {28'd0, dom_rst_n}, 32'hF);
        check("wd_done36", {31'd0, seq_done},  32'h1);

        // Soft request and bite together in RUN at edge 40.
        goto(39);
        soft_rst_req = 1'b1;
        wdt_bite     = 1'b1;
        goto(40);
        soft_rst_req = 1'b0;
        wdt_bite     = 1'b0;
        check("sim_dom40", {28'd0, dom_rst_n},    32'h0);
        check("sim_ack40", {31'd0, soft_rst_ack}, 32'h1);
`ifdef RESET_CAUSE_EN
        check("sim_cause", {30'd0, reset_cause}, 32'h3);
`endif
        goto(41);
        check("sim_ack41", {31'd0, soft_rst_ack}, 32'h0);
        goto(51);
        check("sim_dom51", {28'd0, dom_rst_n}, 32'h0);
        goto(52);
        check("sim_dom52", {28'd0, dom_rst_n}, 32'h1);
        goto(64);
        check("sim_dom64",  {28'd0, dom_rst_n}, 32'hF);
        check("sim_done64", {31'd0, seq_done},  32'h1);

        // Bite at 70 enters HOLD, second bite at 74 restarts the hold.
        goto(69);
        wdt_bite = 1'b1;
        goto(70);
        wdt_bite = 1'b0;
        check("rh_dom70", {28'd0, dom_rst_n}, 32'h0);
        goto(73);
        wdt_bite = 1'b1;
        goto(74);
        wdt_bite = 1'b0;
        goto(82);
        check("rh_dom82", {28'd0, dom_rst_n}, 32'h0);
        goto(85);
        check("rh_dom85", {28'd0, dom_rst_n}, 32'h0);
        goto(86);
        check("rh_dom86", {28'd0, dom_rst_n}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
